// File: rtl/iob_master_pkg.sv
// iob_master_pkg: state encoding, parameter defaults and counter widths shared by the IOB master.
package iob_master_pkg;
    typedef enum logic [2:0] {IDLE, AS, DS, VPAW, TERM, RECOV} state_e;
    localparam int IOB_DIV_DEF   = 2;
    localparam int VPA_STEPS_DEF = 10;
    localparam int TIMEOUT_DEF   = 255;
    localparam int DIV_W = 4;
    localparam int VPA_W = 8;
    localparam int TO_W  = 8;
endpackage

// File: rtl/iob_master_if.sv
// iob_master_if: FSB request/response and IOB strobe/termination signals of the IOB master.
interface iob_master_if;
    logic BACT, IOCS, IOPWCS, nWE, nUDS, nLDS;
    logic IOReady, IOBERR, PWErr, IOBusy;
    logic nAS_IOB, nUDS_IOB, nLDS_IOB, nWE_IOB;
    logic nDTACK_IOB, nVPA_IOB, nBERR_IOB;
    logic nADoutLE, nDoutOE, nDinLE;
    modport master (
        input  BACT, IOCS, IOPWCS, nWE, nUDS, nLDS, nDTACK_IOB, nVPA_IOB, nBERR_IOB,
        output IOReady, IOBERR, PWErr, IOBusy, nAS_IOB, nUDS_IOB, nLDS_IOB, nWE_IOB,
               nADoutLE, nDoutOE, nDinLE
    );
    modport slave (
        output BACT, IOCS, IOPWCS, nWE, nUDS, nLDS, nDTACK_IOB, nVPA_IOB, nBERR_IOB,
        input  IOReady, IOBERR, PWErr, IOBusy, nAS_IOB, nUDS_IOB, nLDS_IOB, nWE_IOB,
               nADoutLE, nDoutOE, nDinLE
    );
endinterface

// File: rtl/iob_steptimer.sv
// iob_steptimer: one-CLK step strobe every IOB_DIV CLKs, realigned whenever restart_i is high.
module iob_steptimer
    import iob_master_pkg::*;
#(
    parameter int IOB_DIV = IOB_DIV_DEF
) (
    input  logic CLK,
    input  logic nRES,
    input  logic restart_i,
    output logic step_o
);
    localparam logic [DIV_W-1:0] LOAD = DIV_W'(IOB_DIV - 1);
    logic [DIV_W-1:0] cnt_q, cnt_d;
    assign step_o = cnt_q == '0;
    assign cnt_d  = (restart_i || step_o) ? LOAD : cnt_q - DIV_W'(1);
    always_ff @(posedge CLK or negedge nRES)
        if (!nRES) cnt_q <= LOAD;
        else cnt_q <= cnt_d;
endmodule

// File: rtl/iob_master.sv
// iob_master: runs one 68000-style AS/DS/DTACK cycle on the IOB per FSB request;
// posted writes are acknowledged after address latch and completed in the background.
module iob_master
    import iob_master_pkg::*;
#(
    parameter int IOB_DIV   = IOB_DIV_DEF,
    parameter int VPA_STEPS = VPA_STEPS_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input logic CLK,
    input logic nRES,
    iob_master_if.master bus
);
    state_e state_q, state_d;
    logic step, req, start, act, dsa, term_err, rdy_set, err_set;
    logic lat_q, we_q, uds_q, lds_q, pw_q, err_q, abort_q, term_q;
    logic dtack_q, vpa_q, berr_q;
    logic nas_q, nuds_q, nlds_q, nwe_q, ndoe_q, ndin_q;
    logic ioready_q, ioberr_q, pwerr_q;
    logic [TO_W-1:0] to_q;
    logic [VPA_W-1:0] vc_q;

    iob_steptimer #(.IOB_DIV(IOB_DIV)) u_step (
        .CLK,
        .nRES,
        .restart_i(state_d != state_q),
        .step_o(step)
    );

    assign req     = bus.BACT & bus.IOCS & ~(ioready_q | ioberr_q);
    assign start   = (state_q == IDLE) & ~lat_q & req;
    assign act     = state_q inside {AS, DS, VPAW, TERM};
    assign dsa     = state_q inside {DS, VPAW, TERM};
    assign rdy_set = (lat_q & pw_q) | (term_q & ~pw_q & ~err_q & ~abort_q);
    assign err_set = term_q & ~pw_q & err_q & ~abort_q;

    always_ff @(posedge CLK or negedge nRES)
        if (!nRES) state_q <= IDLE;
        else state_q <= state_d;

    always_comb begin
        state_d  = state_q;
        term_err = 1'b0;
        unique case (state_q)
            IDLE:  state_d = lat_q ? AS : IDLE;
            AS:    state_d = step ? DS : AS;
            DS: begin
                term_err = ~berr_q | (to_q == TO_W'(TIMEOUT - 1));
                state_d  = (term_err | ~dtack_q) ? TERM : ~vpa_q ? VPAW : DS;
            end
            VPAW: begin
                term_err = ~berr_q;
                state_d  = (term_err | (step & (vc_q == VPA_W'(VPA_STEPS - 1)))) ? TERM : VPAW;
            end
            TERM:  state_d = RECOV;
            RECOV: state_d = step ? IDLE : RECOV;
            default: state_d = IDLE;
        endcase
    end

    // IOB strobes are registered from the current state, so pins trail the FSM by one CLK
    always_ff @(posedge CLK or negedge nRES)
        if (!nRES) begin
            {dtack_q, vpa_q, berr_q} <= 3'b111;
            {lat_q, we_q, uds_q, lds_q, pw_q, err_q, abort_q, term_q} <= 8'b0111_0000;
            {nas_q, nuds_q, nlds_q, nwe_q, ndoe_q, ndin_q} <= 6'b11_1111;
            {ioready_q, ioberr_q, pwerr_q} <= 3'b000;
            to_q <= '0;
            vc_q <= '0;
        end else begin
            {dtack_q, vpa_q, berr_q} <= {bus.nDTACK_IOB, bus.nVPA_IOB, bus.nBERR_IOB};
            lat_q <= start;
            if (start) {we_q, uds_q, lds_q, pw_q} <= {bus.nWE, bus.nUDS, bus.nLDS, bus.IOPWCS & ~bus.nWE};
            err_q   <= ~start & (err_q | term_err);
            abort_q <= ~start & (abort_q | (~bus.BACT & (lat_q | (state_q != IDLE))));
            term_q  <= state_q == TERM;
            to_q <= (state_q == DS) ? to_q + TO_W'(~&to_q) : '0;
            vc_q <= (state_q == VPAW) ? vc_q + VPA_W'(step) : '0;
            nas_q  <= ~act;
            nwe_q  <= ~act | we_q;
            ndoe_q <= ~act | we_q;
            nuds_q <= ~dsa | uds_q;
            nlds_q <= ~dsa | lds_q;
            ndin_q <= ~((state_q == TERM) & we_q);
            ioready_q <= bus.BACT & (ioready_q | rdy_set);
            ioberr_q  <= bus.BACT & (ioberr_q | err_set);
            pwerr_q   <= pwerr_q | (term_q & pw_q & err_q);
        end

    assign bus.IOReady  = ioready_q;
    assign bus.IOBERR   = ioberr_q;
    assign bus.PWErr    = pwerr_q;
    assign bus.IOBusy   = state_q != IDLE;
    assign bus.nAS_IOB  = nas_q;
    assign bus.nUDS_IOB = nuds_q;
    assign bus.nLDS_IOB = nlds_q;
    assign bus.nWE_IOB  = nwe_q;
    assign bus.nDoutOE  = ndoe_q;
    assign bus.nDinLE   = ndin_q;
    assign bus.nADoutLE = ~lat_q;
endmodule

// File: tb/tb_iob_master.sv
// tb_iob_master: directed cycle-exact checks of read, posted write, VPA, timeout, BERR and reset behaviour.
module tb_iob_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int npass = 0;
    int ntot = 0;

    iob_master_if bus ();

    iob_master #(.IOB_DIV(2), .VPA_STEPS(10), .TIMEOUT(255)) dut (
        .CLK(clk),
        .nRES(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // {nAS, nUDS, nLDS, nWE, nDoutOE, nDinLE, nADoutLE} and {IOReady, IOBERR, PWErr, IOBusy}
    wire [6:0] strb = {bus.nAS_IOB, bus.nUDS_IOB, bus.nLDS_IOB, bus.nWE_IOB, bus.nDoutOE, bus.nDinLE, bus.nADoutLE};
    wire [6:0] stat = {3'b000, bus.IOReady, bus.IOBERR, bus.PWErr, bus.IOBusy};

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle_bus;
        bus.BACT = 1'b0; bus.IOCS = 1'b0; bus.IOPWCS = 1'b0;
        bus.nWE = 1'b1; bus.nUDS = 1'b1; bus.nLDS = 1'b1;
        bus.nDTACK_IOB = 1'b1; bus.nVPA_IOB = 1'b1; bus.nBERR_IOB = 1'b1;
    endtask

    task automatic req(input logic we, input logic pw, input logic uds, input logic lds);
        bus.BACT = 1'b1; bus.IOCS = 1'b1; bus.IOPWCS = pw;
        bus.nWE = we; bus.nUDS = uds; bus.nLDS = lds;
    endtask

    // upper-byte read terminated by DTACK (plus BERR if berr) driven 3 CLK into DS
    task automatic rd(input string tag, input logic berr, input logic drop, input logic pe, input logic [6:0] fin);
        logic [6:0] base;
        base = {5'b0, pe, 1'b0};
        req(1'b1, 1'b0, 1'b0, 1'b1);
        tick(1); chk({tag, " ale"}, strb, 7'h7E); chk({tag, " lat st"}, stat, base);
        tick(1); chk({tag, " as0"}, strb, 7'h7F); chk({tag, " busy"}, stat, base | 7'h01);
        tick(1); chk({tag, " as"}, strb, 7'h3F);
        tick(2); chk({tag, " ds"}, strb, 7'h1F);
        if (drop) bus.BACT = 1'b0;
        tick(2); chk({tag, " wait"}, strb, 7'h1F);
        bus.nDTACK_IOB = 1'b0;
        bus.nBERR_IOB = ~berr;
        tick(3); chk({tag, " din"}, strb, 7'h1D);
        tick(1); chk({tag, " end strb"}, strb, 7'h7F); chk({tag, " end st"}, stat, fin);
        idle_bus;
        tick(2); chk({tag, " clr"}, stat, base);
    endtask

    initial begin
        idle_bus;
        tick(2);
        chk("reset strb", strb, 7'h7F);
        chk("reset st", stat, 7'h00);
        rst_n = 1'b1;
        tick(1);

        rd("read", 1'b0, 1'b0, 1'b0, 7'b0001001);

        req(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1); chk("pw ale", strb, 7'h7E); chk("pw lat st", stat, 7'h00);
        tick(1); chk("pw ack strb", strb, 7'h7F); chk("pw ack", stat, 7'h09);
        bus.BACT = 1'b0;
        tick(1); chk("pw as", strb, 7'h33); chk("pw rel", stat, 7'h01);
        req(1'b1, 1'b0, 1'b1, 1'b0);
        tick(2); chk("pw ds", strb, 7'h03);
        bus.nDTACK_IOB = 1'b0;
        tick(3); chk("pw term", strb, 7'h03);
        bus.nDTACK_IOB = 1'b1;
        tick(1); chk("pw recov", strb, 7'h7F); chk("pw no ack", stat, 7'h01);
        tick(1); chk("rd2 stall", strb, 7'h7F); chk("rd2 stall st", stat, 7'h00);
        tick(1); chk("rd2 ale", strb, 7'h7E);
        tick(4); chk("rd2 ds", strb, 7'h2F);
        bus.nDTACK_IOB = 1'b0;
        tick(3); chk("rd2 din", strb, 7'h2D);
        tick(1); chk("rd2 ack", stat, 7'h09);
        idle_bus;
        tick(1); chk("rd2 clr", stat, 7'h00);

        req(1'b1, 1'b0, 1'b0, 1'b1);
        tick(7); chk("vpa ds", strb, 7'h1F);
        bus.nVPA_IOB = 1'b0;
        tick(2); chk("vpa wait", stat, 7'h01);
        bus.nVPA_IOB = 1'b1;
        tick(20); chk("vpa pre term", strb, 7'h1F);
        tick(1); chk("vpa din", strb, 7'h1D);
        tick(1); chk("vpa ack", stat, 7'h09);
        idle_bus;
        tick(2); chk("vpa clr", stat, 7'h00);

        req(1'b1, 1'b0, 1'b0, 1'b1);
        tick(259); chk("to pre", strb, 7'h1F); chk("to pre st", stat, 7'h01);
        tick(1); chk("to din", strb, 7'h1D); chk("to din st", stat, 7'h01);
        tick(1); chk("to strb", strb, 7'h7F); chk("to berr", stat, 7'h05);
        idle_bus;
        tick(2); chk("to clr", stat, 7'h00);

        req(1'b0, 1'b1, 1'b0, 1'b0);
        tick(2); chk("pto ack", stat, 7'h09);
        bus.BACT = 1'b0;
        tick(257); chk("pto pre", strb, 7'h03); chk("pto pre st", stat, 7'h01);
        tick(1); chk("pto term", strb, 7'h03); chk("pto term st", stat, 7'h01);
        tick(1); chk("pto strb", strb, 7'h7F); chk("pto pwerr", stat, 7'h03);
        tick(1); chk("pto idle", stat, 7'h02);
        idle_bus;

        rd("berr+dtack", 1'b1, 1'b0, 1'b1, 7'b0000111);
        rd("bact drop", 1'b0, 1'b1, 1'b1, 7'b0000011);

        req(1'b1, 1'b0, 1'b0, 1'b1);
        tick(6); chk("rst ds", strb, 7'h1F); chk("rst ds st", stat, 7'h03);
        rst_n = 1'b0;
        #1;
        chk("rst async strb", strb, 7'h7F);
        chk("rst async st", stat, 7'h00);
        tick(1);
        rst_n = 1'b1;
        rd("after rst", 1'b0, 1'b0, 1'b0, 7'b0001001);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
